effect_chain_sequencer: RTL and testbench

Per-sample controller for the pedal-board effect chain. On each incoming audio frame it walks the effect stages in chain order (overdrive, tremolo, then later stages), handshakes START/DONE with each enabled stage, and skips or force-bypasses stages as needed. When the frame is finished it emits a commit pulse so the board output register can capture the chain result. It sits between the codec frame strobe, the front-panel switches and the effect modules, and replaces the free-running start/done loop currently in the board top level.

---
 rtl/pedal_pkg.sv | 19 +
 rtl/stage_watchdog.sv | 38 +++
 rtl/effect_chain_sequencer.sv | 161 ++++++++++++++++
 tb/tb_effect_chain_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pedal_pkg.sv
// Shared types and constants for the pedal-board effect chain controllers.
package pedal_pkg;

   localparam int N_STAGES_DEF = 4;

   localparam int STG_OD   = 0;
   localparam int STG_TREM = 1;
   localparam int STG_VIB  = 2;
   localparam int STG_ECHO = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_WAIT,
      ST_RELEASE,
      ST_COMMIT
   } seq_state_t;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage handshake watchdog: expires once TIMEOUT cycles have been spent
// in WAIT/RELEASE since the last clear (counting the current cycle).
module stage_watchdog #(
   parameter int TIMEOUT = 1023
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic run_i,
   output logic expired_o
);

   localparam int              W    = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0]    LOAD = W'(TIMEOUT - 1);

   logic [W-1:0] remain_q, remain_d;

   // Down-counter of cycles left; holds at zero so expiry stays visible.
   always_comb begin
      remain_d = remain_q;
      if (clear_i) begin
         remain_d = LOAD;
      end else if (run_i && (remain_q != '0)) begin
         remain_d = remain_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         remain_q <= LOAD;
      end else begin
         remain_q <= remain_d;
      end
   end

   assign expired_o = (remain_q == '0);

endmodule

// File: rtl/effect_chain_sequencer.sv
// Per-frame START/DONE sequencer for the effect chain, with a one-deep frame
// buffer, per-stage watchdog and sticky overrun/timeout flags.
//
// state      | meaning
// IDLE       | no frame in progress; accepts a strobe or the pending frame
// SCAN       | looks at en_q[idx]; skips disabled stages one per cycle
// WAIT       | start[idx] high until done[idx] or watchdog expiry
// RELEASE    | start low, waiting for done[idx] to drop (or expiry)
// COMMIT     | one-cycle commit pulse, chain output is final
module effect_chain_sequencer
   import pedal_pkg::*;
#(
   parameter int N_STAGES = N_STAGES_DEF,
   parameter int TIMEOUT  = 1023
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        frame_valid_i,
   input  logic [N_STAGES-1:0]         enable_i,
   input  logic [N_STAGES-1:0]         done_i,
   input  logic                        clear_err_i,
   output logic [N_STAGES-1:0]         start_o,
   output logic [N_STAGES-1:0]         bypass_o,
   output logic [$clog2(N_STAGES)-1:0] cur_stage_o,
   output logic                        commit_o,
   output logic                        busy_o,
   output logic                        overrun_o,
   output logic                        timeout_err_o
);

   localparam int            IW   = $clog2(N_STAGES);
   localparam logic [IW-1:0] LAST = IW'(N_STAGES - 1);

   seq_state_t          state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [N_STAGES-1:0] en_q, en_d;
   logic [N_STAGES-1:0] bypass_q, bypass_d;
   logic                pending_q, pending_d;
   logic                overrun_q, overrun_d;
   logic                terr_q, terr_d;
   logic                ovr_set, terr_set;
   logic                wd_clear, wd_run, wd_expired;

   stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (wd_clear),
      .run_i     (wd_run),
      .expired_o (wd_expired)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         en_q      <= '0;
         bypass_q  <= '1;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         terr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         en_q      <= en_d;
         bypass_q  <= bypass_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         terr_q    <= terr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      en_d      = en_q;
      bypass_d  = bypass_q;
      pending_d = pending_q;
      ovr_set   = 1'b0;
      terr_set  = 1'b0;
      wd_clear  = 1'b0;
      wd_run    = (state_q == ST_WAIT) || (state_q == ST_RELEASE);

      unique case (state_q)
         ST_IDLE: begin
            if (frame_valid_i || pending_q) begin
               en_d      = enable_i;
               bypass_d  = ~enable_i;
               idx_d     = '0;
               // A fresh strobe arriving while the buffered frame launches is kept.
               pending_d = pending_q && frame_valid_i;
               state_d   = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (en_q[idx_q]) begin
               wd_clear = 1'b1;
               state_d  = ST_WAIT;
            end else if (idx_q == LAST) begin
               state_d = ST_COMMIT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_WAIT: begin
            if (done_i[idx_q]) begin
               state_d = ST_RELEASE;
            end else if (wd_expired) begin
               terr_set         = 1'b1;
               bypass_d[idx_q]  = 1'b1;
               state_d          = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!done_i[idx_q] || wd_expired) begin
               if (done_i[idx_q]) begin
                  terr_set        = 1'b1;
                  bypass_d[idx_q] = 1'b1;
               end
               if (idx_q == LAST) begin
                  state_d = ST_COMMIT;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_SCAN;
               end
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (frame_valid_i && (state_q != ST_IDLE)) begin
         if (!pending_q) begin
            pending_d = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end

      // Set beats clear when both land in the same cycle.
      overrun_d = ovr_set  ? 1'b1 : (clear_err_i ? 1'b0 : overrun_q);
      terr_d    = terr_set ? 1'b1 : (clear_err_i ? 1'b0 : terr_q);
   end

   always_comb begin
      start_o = '0;
      if (state_q == ST_WAIT) begin
         start_o[idx_q] = 1'b1;
      end
      commit_o      = (state_q == ST_COMMIT);
      busy_o        = (state_q != ST_IDLE);
      bypass_o      = bypass_q;
      cur_stage_o   = idx_q;
      overrun_o     = overrun_q;
      timeout_err_o = terr_q;
   end

endmodule

// File: tb/tb_effect_chain_sequencer.sv
// Scoreboard bench for effect_chain_sequencer: a frame-level model predicts
// which stages get started and the final bypass word of every committed frame.
module tb_effect_chain_sequencer;

   logic       clk;
   logic       rst;
   logic       frame_valid;
   logic [3:0] enable;
   logic [3:0] done;
   logic       clear_err;
   logic [3:0] start_o;
   logic [3:0] bypass_o;
   logic [1:0] cur_stage_o;
   logic       commit_o;
   logic       busy_o;
   logic       overrun_o;
   logic       timeout_err_o;

   effect_chain_sequencer #(.N_STAGES(4), .TIMEOUT(15)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .frame_valid_i (frame_valid),
      .enable_i      (enable),
      .done_i        (done),
      .clear_err_i   (clear_err),
      .start_o       (start_o),
      .bypass_o      (bypass_o),
      .cur_stage_o   (cur_stage_o),
      .commit_o      (commit_o),
      .busy_o        (busy_o),
      .overrun_o     (overrun_o),
      .timeout_err_o (timeout_err_o)
   );

   typedef struct {
      logic [3:0] mask;
      logic [3:0] byp;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   commits = 0;
   int   start_cnt[4];
   int   lat[4];
   int   rel[4];
   bit   stuck[4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Frame-level expectation: enabled stages get started in order; bypass is
   // the inverse of the snapshot plus any stage that never answered.
   task automatic expect_frame(input logic [3:0] en);
      exp_t e;
      logic [3:0] sm;
      for (int s = 0; s < 4; s++) sm[s] = stuck[s];
      e.mask = en;
      e.byp  = ~en | (en & sm);
      exp_q.push_back(e);
   endtask

   task automatic strobe();
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy_o) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(n < 3000), 1);
      @(negedge clk);
   endtask

   // Effect-stage models: done rises lat cycles into START, drops rel cycles
   // after START falls; a stuck stage never answers.
   initial begin
      int cnt[4];
      int rc[4];
      done = 4'b0000;
      for (int s = 0; s < 4; s++) begin cnt[s] = 0; rc[s] = 0; end
      forever begin
         @(negedge clk);
         for (int s = 0; s < 4; s++) begin
            if (rst) begin
               done[s] = 1'b0; cnt[s] = 0; rc[s] = 0;
            end else if (start_o[s]) begin
               rc[s] = 0;
               if (!stuck[s]) begin
                  cnt[s]++;
                  if (cnt[s] >= lat[s]) done[s] = 1'b1;
               end
            end else begin
               cnt[s] = 0;
               if (done[s]) begin
                  rc[s]++;
                  if (rc[s] >= rel[s]) begin done[s] = 1'b0; rc[s] = 0; end
               end
            end
         end
      end
   end

   // Monitor: per-cycle START checks and scoreboard pop on every commit.
   initial begin
      logic [3:0] seen;
      int         last;
      exp_t       e;
      seen = 4'b0000;
      last = -1;
      for (int s = 0; s < 4; s++) start_cnt[s] = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            seen = 4'b0000;
            last = -1;
         end else begin
            if (start_o != 4'b0000) begin
               check("start_onehot", $countones(start_o), 1);
               for (int s = 0; s < 4; s++) begin
                  if (start_o[s]) begin
                     start_cnt[s]++;
                     if (!seen[s]) begin
                        check("start_order", int'(s > last), 1);
                        check("cur_stage", int'(cur_stage_o), s);
                        seen[s] = 1'b1;
                        last    = s;
                     end
                  end
               end
            end
            if (commit_o) begin
               commits++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_commit actual=1 expected=0 at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_stages", int'(seen), int'(e.mask));
                  check("commit_bypass", int'(bypass_o), int'(e.byp));
               end
               seen = 4'b0000;
               last = -1;
            end
         end
      end
   end

   initial begin
      int c0;
      int sc0;
      int extras;
      logic [3:0] en;
      logic [3:0] sm;

      rst = 1'b1; frame_valid = 1'b0; enable = 4'b0000; clear_err = 1'b0;
      for (int s = 0; s < 4; s++) begin lat[s] = 5; rel[s] = 1; stuck[s] = 1'b0; end
      repeat (3) @(negedge clk);
      check("rst_start", int'(start_o), 0);
      check("rst_bypass", int'(bypass_o), 4'hf);
      check("rst_busy", int'(busy_o), 0);
      check("rst_commit", int'(commit_o), 0);
      check("rst_cur_stage", int'(cur_stage_o), 0);
      check("rst_flags", int'({overrun_o, timeout_err_o}), 0);
      rst = 1'b0;
      @(negedge clk);

      // Reset asserted while stage 0 is in WAIT.
      enable = 4'b0001; stuck[0] = 1'b1;
      strobe();
      repeat (4) @(negedge clk);
      check("midwait_start", int'(start_o), 1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("midrst_start", int'(start_o), 0);
      check("midrst_bypass", int'(bypass_o), 4'hf);
      check("midrst_busy", int'(busy_o), 0);
      check("midrst_flags", int'({overrun_o, timeout_err_o}), 0);
      stuck[0] = 1'b0;
      @(negedge clk);

      // All stages disabled: commit exactly in t+5, idle in t+6.
      enable = 4'b0000;
      expect_frame(enable);
      strobe();
      check("dis_busy_t1", int'(busy_o), 1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k <= 4) check("dis_commit_timing", int'(commit_o), int'(k == 4));
         else        check("dis_busy_t6", int'(busy_o), 0);
      end
      wait_idle("dis_drain");

      // Normal handshake on stages 0 and 1.
      enable = 4'b0011;
      c0 = commits;
      expect_frame(enable);
      strobe();
      check("hs_bypass_early", int'(bypass_o), 4'b1100);
      wait_idle("hs_drain");
      check("hs_commits", commits - c0, 1);

      // Stage 0 never answers: watchdog abandons it after 15 START cycles.
      enable = 4'b0001; stuck[0] = 1'b1;
      sc0 = start_cnt[0];
      expect_frame(enable);
      strobe();
      wait_idle("to_drain");
      check("to_start_len", start_cnt[0] - sc0, 15);
      check("to_flag", int'(timeout_err_o), 1);
      pulse_clear();
      check("to_clear", int'(timeout_err_o), 0);
      stuck[0] = 1'b0;

      // Three strobes in one busy frame: one queued, one dropped.
      enable = 4'b0110;
      c0 = commits;
      expect_frame(enable);
      expect_frame(enable);
      strobe();
      strobe();
      strobe();
      wait_idle("ovr_drain");
      check("ovr_commits", commits - c0, 2);
      check("ovr_flag", int'(overrun_o), 1);
      pulse_clear();
      check("ovr_clear", int'(overrun_o), 0);

      // Enable change mid-frame only affects the next frame.
      enable = 4'b0011;
      expect_frame(enable);
      strobe();
      c0 = 0;
      while (!start_o[0] && c0 < 50) begin @(negedge clk); c0++; end
      check("snap_reach_wait", int'(c0 < 50), 1);
      enable = 4'b0001;
      check("snap_bypass_hold", int'(bypass_o), 4'b1100);
      wait_idle("snap_drain1");
      expect_frame(enable);
      strobe();
      wait_idle("snap_drain2");

      // Randomized frames, latencies, stuck stages and extra strobes.
      for (int it = 0; it < 40; it++) begin
         en = 4'($urandom_range(0, 15));
         for (int s = 0; s < 4; s++) begin
            lat[s]   = $urandom_range(1, 6);
            rel[s]   = $urandom_range(1, 3);
            stuck[s] = ($urandom_range(0, 5) == 0);
            sm[s]    = stuck[s];
         end
         extras = $urandom_range(0, 2);
         enable = en;
         pulse_clear();
         c0 = commits;
         expect_frame(en);
         if (extras >= 1) expect_frame(en);
         strobe();
         for (int x = 0; x < extras; x++) strobe();
         wait_idle("rnd_drain");
         check("rnd_commits", commits - c0, (extras >= 1) ? 2 : 1);
         check("rnd_overrun", int'(overrun_o), int'(extras == 2));
         check("rnd_timeout", int'(timeout_err_o), int'((en & sm) != 4'b0000));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
